// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
  logic        req0;
  logic        we0;
  logic [15:0] addr0;
  logic [31:0] wdata0;
  logic        ack0;
  logic [31:0] rdata0;
  logic        stall0;

  logic        req1;
  logic        we1;
  logic [15:0] addr1;
  logic [31:0] wdata1;
  logic        ack1;
  logic [31:0] rdata1;

  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    output ack0, rdata0, stall0,
    input  req1, we1, addr1, wdata1,
    output ack1, rdata1,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  ack0, rdata0, stall0,
    output req1, we1, addr1, wdata1,
    input  ack1, rdata1,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port data memory.
// All memory strobes, address and data are registered; acks pulse for one cycle.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [15:0] mem_address_q, mem_address_d;
  logic [31:0] mem_writedata_q, mem_writedata_d;

  logic sel1;
  logic we_sel;

  // Port 1 wins when it alone requests, or on a tie when port 0 was served last.
  assign sel1   = bus.req1 && (!bus.req0 || !last_grant_q);
  assign we_sel = sel1 ? bus.we1 : bus.we0;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    last_grant_d    = last_grant_q;
    gnt_d           = gnt_q;
    we_d            = we_q;
    ack0_d          = 1'b0;
    ack1_d          = 1'b0;
    rdata0_d        = rdata0_q;
    rdata1_d        = rdata1_q;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;

    case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          gnt_d           = sel1;
          last_grant_d    = sel1;
          we_d            = we_sel;
          mem_address_d   = sel1 ? bus.addr1 : bus.addr0;
          mem_writedata_d = sel1 ? bus.wdata1 : bus.wdata0;
          cnt_d           = WaitInit;
          mem_read_d      = !we_sel;
          mem_write_d     = we_sel && (WaitInit == 4'd0);
          state_d         = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q != 4'd0) begin
          cnt_d       = cnt_q - 4'd1;
          mem_read_d  = !we_q;
          // Write strobe only in the last access cycle: one write per access.
          mem_write_d = we_q && (cnt_q == 4'd1);
        end else begin
          state_d = StDone;
          if (!we_q) begin
            if (gnt_q) rdata1_d = bus.mem_readdata;
            else       rdata0_d = bus.mem_readdata;
          end
          ack0_d = !gnt_q;
          ack1_d = gnt_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= 4'd0;
      last_grant_q    <= 1'b1;
      gnt_q           <= 1'b0;
      we_q            <= 1'b0;
      ack0_q          <= 1'b0;
      ack1_q          <= 1'b0;
      rdata0_q        <= 32'd0;
      rdata1_q        <= 32'd0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= 16'd0;
      mem_writedata_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      last_grant_q    <= last_grant_d;
      gnt_q           <= gnt_d;
      we_q            <= we_d;
      ack0_q          <= ack0_d;
      ack1_q          <= ack1_d;
      rdata0_q        <= rdata0_d;
      rdata1_q        <= rdata1_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  assign bus.ack0          = ack0_q;
  assign bus.ack1          = ack1_q;
  assign bus.rdata0        = rdata0_q;
  assign bus.rdata1        = rdata1_q;
  assign bus.stall0        = bus.req0 & ~ack0_q;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: DUT A has WAIT_CYCLES=0, DUT B has WAIT_CYCLES=2, each with its own memory.
module tb_mem_arbiter;
  logic clk;
  logic rst;

  mem_arbiter_if bus_a ();
  mem_arbiter_if bus_b ();

  mem_arbiter #(.WAIT_CYCLES(0)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  mem_arbiter #(.WAIT_CYCLES(2)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic        ld_en;
  logic        ld_sel;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  int          wr_cnt_a;
  int          wr_cnt_b;
  int          ack0_cnt_a;
  bit          overlap;

  int checks;
  int failures;

  assign bus_a.mem_readdata = mem_a[bus_a.mem_address[7:0]];
  assign bus_b.mem_readdata = mem_b[bus_b.mem_address[7:0]];

  always @(posedge clk) begin
    if (ld_en && !ld_sel) mem_a[ld_addr] <= ld_data;
    if (bus_a.mem_write) begin
      mem_a[bus_a.mem_address[7:0]] <= bus_a.mem_writedata;
      wr_cnt_a <= wr_cnt_a + 1;
    end
    if (bus_a.ack0) ack0_cnt_a <= ack0_cnt_a + 1;
  end

  always @(posedge clk) begin
    if (ld_en && ld_sel) mem_b[ld_addr] <= ld_data;
    if (bus_b.mem_write) begin
      mem_b[bus_b.mem_address[7:0]] <= bus_b.mem_writedata;
      wr_cnt_b <= wr_cnt_b + 1;
    end
  end

  always @(negedge clk) begin
    if ((bus_a.mem_read && bus_a.mem_write) || (bus_b.mem_read && bus_b.mem_write) ||
        (bus_a.ack0 && bus_a.ack1) || (bus_b.ack0 && bus_b.ack1))
      overlap <= 1'b1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic sel, input logic [7:0] addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_addr = addr;
    ld_data = data;
    step();
    ld_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Port 0 access on DUT A; returns in the IDLE cycle after the ack.
  task automatic access0_a(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
    int n;
    bus_a.req0   = 1'b1;
    bus_a.we0    = we;
    bus_a.addr0  = addr;
    bus_a.wdata0 = wdata;
    n = 0;
    step();
    while (bus_a.ack0 !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check1("access0_a_ack_seen", n < 30, 1'b1);
    bus_a.req0 = 1'b0;
    step();
    check1("access0_a_ack_one_cycle", bus_a.ack0, 1'b0);
  endtask

  initial begin
    int w0;
    int a0;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    ld_en    = 1'b0;
    ld_sel   = 1'b0;
    ld_addr  = 8'd0;
    ld_data  = 32'd0;
    bus_a.req0 = 1'b0; bus_a.we0 = 1'b0; bus_a.addr0 = 16'd0; bus_a.wdata0 = 32'd0;
    bus_a.req1 = 1'b0; bus_a.we1 = 1'b0; bus_a.addr1 = 16'd0; bus_a.wdata1 = 32'd0;
    bus_b.req0 = 1'b0; bus_b.we0 = 1'b0; bus_b.addr0 = 16'd0; bus_b.wdata0 = 32'd0;
    bus_b.req1 = 1'b0; bus_b.we1 = 1'b0; bus_b.addr1 = 16'd0; bus_b.wdata1 = 32'd0;

    preload(1'b0, 8'd5, 32'hDEADBEEF);
    preload(1'b0, 8'd7, 32'h77777777);
    preload(1'b0, 8'd1, 32'h00001111);
    preload(1'b0, 8'd2, 32'h00002222);
    preload(1'b1, 8'hA0, 32'hCAFEF00D);
    preload(1'b1, 8'h10, 32'h11111111);
    do_reset();

    // Reset state
    check1("rst_ack0", bus_a.ack0, 1'b0);
    check1("rst_ack1", bus_a.ack1, 1'b0);
    check32("rst_rdata0", bus_a.rdata0, 32'd0);
    check32("rst_rdata1", bus_a.rdata1, 32'd0);
    check1("rst_mem_read", bus_a.mem_read, 1'b0);
    check1("rst_mem_write", bus_a.mem_write, 1'b0);
    check32("rst_mem_address", {16'd0, bus_a.mem_address}, 32'd0);
    check32("rst_mem_writedata", bus_a.mem_writedata, 32'd0);
    check1("rst_stall0", bus_a.stall0, 1'b0);

    // Single read, WAIT_CYCLES=0
    bus_a.req0 = 1'b1; bus_a.we0 = 1'b0; bus_a.addr0 = 16'd5;
    #1;
    check1("rd_c0_stall0", bus_a.stall0, 1'b1);
    check1("rd_c0_mem_read", bus_a.mem_read, 1'b0);
    step();
    check1("rd_c1_mem_read", bus_a.mem_read, 1'b1);
    check32("rd_c1_addr", {16'd0, bus_a.mem_address}, 32'd5);
    check1("rd_c1_stall0", bus_a.stall0, 1'b1);
    check1("rd_c1_ack0", bus_a.ack0, 1'b0);
    step();
    check1("rd_c2_ack0", bus_a.ack0, 1'b1);
    check32("rd_c2_rdata0", bus_a.rdata0, 32'hDEADBEEF);
    check1("rd_c2_mem_read", bus_a.mem_read, 1'b0);
    check1("rd_c2_stall0", bus_a.stall0, 1'b0);
    bus_a.req0 = 1'b0;
    step();
    check1("rd_c3_ack0", bus_a.ack0, 1'b0);
    check32("rd_c3_rdata0_held", bus_a.rdata0, 32'hDEADBEEF);

    // Write then read back
    w0 = wr_cnt_a;
    a0 = ack0_cnt_a;
    access0_a(1'b1, 16'd3, 32'h12345678);
    check32("wr_count", 32'(wr_cnt_a - w0), 32'd1);
    check32("wr_mem_word", mem_a[3], 32'h12345678);
    check32("wr_rdata0_unchanged", bus_a.rdata0, 32'hDEADBEEF);
    access0_a(1'b0, 16'd3, 32'd0);
    check32("wr_rd_rdata0", bus_a.rdata0, 32'h12345678);
    check32("wr_rd_ack_count", 32'(ack0_cnt_a - a0), 32'd2);

    // Continuous contention: grants alternate starting with port 0
    do_reset();
    bus_a.req0 = 1'b1; bus_a.we0 = 1'b0; bus_a.addr0 = 16'd1;
    bus_a.req1 = 1'b1; bus_a.we1 = 1'b0; bus_a.addr1 = 16'd2;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      check1("rr_ack0", bus_a.ack0, (c == 2) || (c == 8));
      check1("rr_ack1", bus_a.ack1, (c == 5) || (c == 11));
      if (c == 1) check32("rr_first_addr", {16'd0, bus_a.mem_address}, 32'd1);
      if (c == 4) check32("rr_second_addr", {16'd0, bus_a.mem_address}, 32'd2);
      if (c == 2) check32("rr_rdata0", bus_a.rdata0, 32'h00001111);
      if (c == 5) check32("rr_rdata1", bus_a.rdata1, 32'h00002222);
    end
    bus_a.req0 = 1'b0;
    bus_a.req1 = 1'b0;
    step();

    // WAIT_CYCLES=2 read from port 1
    bus_b.req1 = 1'b1; bus_b.we1 = 1'b0; bus_b.addr1 = 16'h00A0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      check1("w2_mem_read", bus_b.mem_read, (c >= 1) && (c <= 3));
      check1("w2_ack1", bus_b.ack1, c == 4);
      check1("w2_ack0", bus_b.ack0, 1'b0);
      if (c == 4) begin
        check32("w2_rdata1", bus_b.rdata1, 32'hCAFEF00D);
        bus_b.req1 = 1'b0;
      end
    end

    // Reset during a WAIT_CYCLES=2 write from port 1
    w0 = wr_cnt_b;
    bus_b.req1 = 1'b1; bus_b.we1 = 1'b1; bus_b.addr1 = 16'h0010; bus_b.wdata1 = 32'h55AA55AA;
    step();
    check1("rstw_c1_mem_write", bus_b.mem_write, 1'b0);
    rst = 1'b1;
    bus_b.req1 = 1'b0;
    step();
    rst = 1'b0;
    check1("rstw_ack1", bus_b.ack1, 1'b0);
    check1("rstw_mem_write", bus_b.mem_write, 1'b0);
    check1("rstw_mem_read", bus_b.mem_read, 1'b0);
    check32("rstw_mem_address", {16'd0, bus_b.mem_address}, 32'd0);
    check32("rstw_mem_writedata", bus_b.mem_writedata, 32'd0);
    check32("rstw_rdata1", bus_b.rdata1, 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check1("rstw_post_ack1", bus_b.ack1, 1'b0);
    end
    check32("rstw_word", mem_b[8'h10], 32'h11111111);
    check32("rstw_wr_count", 32'(wr_cnt_b - w0), 32'd0);

    // Request dropped and address changed after grant
    bus_a.req0 = 1'b1; bus_a.we0 = 1'b0; bus_a.addr0 = 16'd5;
    step();
    check32("drop_c1_addr", {16'd0, bus_a.mem_address}, 32'd5);
    check1("drop_c1_mem_read", bus_a.mem_read, 1'b1);
    bus_a.req0 = 1'b0;
    bus_a.addr0 = 16'd7;
    #1;
    check1("drop_c1_stall0", bus_a.stall0, 1'b0);
    step();
    check1("drop_c2_ack0", bus_a.ack0, 1'b1);
    check32("drop_c2_rdata0", bus_a.rdata0, 32'hDEADBEEF);
    step();
    check1("drop_c3_ack0", bus_a.ack0, 1'b0);
    check1("drop_c3_mem_read", bus_a.mem_read, 1'b0);
    check32("drop_c3_rdata0", bus_a.rdata0, 32'hDEADBEEF);

    check1("no_strobe_or_ack_overlap", overlap, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
